branch_stack: RTL and testbench
===============================

// Module: branch_stack
// PURPOSE
//  Checkpoint store at the far end of Dispatch's branch-stack interface. Accepts per-bit checkpoints
//  (map table, free-list, ROB tail, parent mask), tracks live branch mask b_mask_reg, retires bits
//  on correct resolve, and on mispredict returns the checkpoint to Dispatch/FreeList/ROB and squashes
//  the branch plus all younger branches. Sits between Dispatch (writer) and Execute branch resolve.
// PARAMETERS
//  B_MASK_WIDTH  4   checkpoint slots; one bit per in-flight branch
//  ARCH_REG_SZ   32  architectural registers
//  PHYS_REG_SZ   64  physical registers
//  PREG_BITS     6   physical register index width
//  ROB_SZ_BITS   5   ROB index width
// PORTS
//  clock             in   1                       clock; all state on posedge
//  reset             in   1                       asynchronous, active-high
//  push_valid        in   B_MASK_WIDTH            bit i set: write slot i this cycle
//  push_map_table    in   B*ARCH_REG_SZ*PREG_BITS per-slot map-table snapshot
//  push_free_list    in   B*PHYS_REG_SZ           per-slot free-list snapshot (1=free)
//  push_rob_tail     in   B*ROB_SZ_BITS           per-slot ROB tail after the branch
//  push_parent_mask  in   B*B_MASK_WIDTH          per-slot mask of older live branches
//  retire_free       in   PHYS_REG_SZ             regs freed by retire this cycle
//  resolve_valid     in   1                       Execute resolves a branch
//  resolve_bit       in   B_MASK_WIDTH            one-hot slot being resolved
//  resolve_mispred   in   1                       1=mispredict, 0=correct
//  b_mask_reg        out  B_MASK_WIDTH            live slots (registered)
//  bs_free_count     out  $clog2(B+1)             number of zero bits in b_mask_reg
//  restore_valid     out  1                       one-cycle restore pulse
//  map_table_restore out  ARCH_REG_SZ*PREG_BITS   restored map table
//  free_list_restore out  PHYS_REG_SZ             restored free list
//  rob_tail_restore  out  ROB_SZ_BITS             restored ROB tail
//  squash_mask       out  B_MASK_WIDTH            squashed slots, valid with restore_valid
//  resolved_mask     out  B_MASK_WIDTH            one-cycle clear broadcast for RS/ROB b_masks
//  bs_error          out  1                       sticky protocol-violation flag
// BEHAVIOUR
//  - Reset (async): b_mask_reg=0, all slots invalid, restore_valid=0, restore data=0,
//    squash_mask=0, resolved_mask=0, bs_error=0, bs_free_count=B_MASK_WIDTH. Reset mid-restore drops it.
//  - Push: slot i written at the edge when push_valid[i]=1; b_mask_reg[i] set at the same edge.
//    Pushing a bit already in b_mask_reg: write ignored, bs_error set.
//  - Free-list tracking: every cycle, each valid slot's free list |= retire_free. A push in the same
//    cycle stores push_free_list | retire_free.
//  - Correct resolve (resolve_valid & !resolve_mispred, bit live): clear the bit in b_mask_reg and in
//    every slot's parent mask, including same-cycle pushes. Next cycle resolved_mask=resolve_bit for
//    one cycle.
//  - Mispredict (resolve_valid & resolve_mispred, bit k live):
//    - S = {k} | {j : parent_mask[j][k]}; clear S from b_mask_reg at the edge.
//    - All push_valid that cycle are ignored: Dispatch is being squashed.
//    - Next cycle: restore_valid=1 for exactly one cycle; restore data = slot k contents,
//      with free list including that cycle's retire_free; squash_mask=S.
//  - Resolve of a non-live bit, or resolve_bit not one-hot: no state change, bs_error set.
//  - resolved_mask and squash_mask are 0 whenever no event occurred the previous cycle.
//  - Full: b_mask_reg all ones gives bs_free_count=0. Dispatch must stall; pushes then fall under
//    the occupied-bit rule.
//  - Slot j freed and re-pushed in the same cycle: free first, then push. Legal only for a correct
//    resolve.
//  - Latency: push->b_mask_reg 1 cycle; resolve->restore/resolved_mask 1 cycle.
// TESTING
//  1 Reset mid-operation: slots 0,1 live, restore pending -> assert reset; b_mask_reg=0, restore_valid=0,
//    bs_free_count=4 immediately.
//  2 Push bit0 (rob_tail=5), then bit1 (parent=0001) -> b_mask_reg=0011; mispredict bit0 ->
//    next cycle restore_valid=1, rob_tail_restore=5, squash_mask=0011, b_mask_reg=0000.
//  3 Slots 0,1 live, parent1=0001; correct resolve bit0 -> b_mask_reg=0010, resolved_mask=0001 for one
//    cycle, parent1=0000; later mispredict bit1 -> squash_mask=0010.
//  4 Push bit2 with free list 0; retire_free[40]=1 two cycles later; mispredict bit2 ->
//    free_list_restore[40]=1.
//  5 Fill all 4 -> bs_free_count=0. Push bit3 again -> bs_error=1, entry unchanged.
//    Resolve non-live bit after freeing -> bs_error stays 1, no state change.
//  6 Same cycle: mispredict bit1 + push bit2 -> push ignored, b_mask_reg[2]=0.
//    Same cycle: correct resolve bit0 + push bit0 -> slot0 rewritten, b_mask_reg[0]=1.

Source files
------------

// File: rtl/branch_stack.sv
// Branch checkpoint store: one slot per in-flight branch mask bit, holding the
// rename map, free list, ROB tail and parent mask needed to recover on mispredict.
module branch_stack #(
  parameter int B_MASK_WIDTH = 4,
  parameter int ARCH_REG_SZ  = 32,
  parameter int PHYS_REG_SZ  = 64,
  parameter int PREG_BITS    = 6,
  parameter int ROB_SZ_BITS  = 5
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic [B_MASK_WIDTH-1:0]                       push_valid,
  input  logic [B_MASK_WIDTH*ARCH_REG_SZ*PREG_BITS-1:0] push_map_table,
  input  logic [B_MASK_WIDTH*PHYS_REG_SZ-1:0]           push_free_list,
  input  logic [B_MASK_WIDTH*ROB_SZ_BITS-1:0]           push_rob_tail,
  input  logic [B_MASK_WIDTH*B_MASK_WIDTH-1:0]          push_parent_mask,
  input  logic [PHYS_REG_SZ-1:0]                        retire_free,
  input  logic                                          resolve_valid,
  input  logic [B_MASK_WIDTH-1:0]                       resolve_bit,
  input  logic                                          resolve_mispred,
  output logic [B_MASK_WIDTH-1:0]                       b_mask_reg,
  output logic [$clog2(B_MASK_WIDTH+1)-1:0]             bs_free_count,
  output logic                                          restore_valid,
  output logic [ARCH_REG_SZ*PREG_BITS-1:0]              map_table_restore,
  output logic [PHYS_REG_SZ-1:0]                        free_list_restore,
  output logic [ROB_SZ_BITS-1:0]                        rob_tail_restore,
  output logic [B_MASK_WIDTH-1:0]                       squash_mask,
  output logic [B_MASK_WIDTH-1:0]                       resolved_mask,
  output logic                                          bs_error
);

  localparam int MAP_W = ARCH_REG_SZ*PREG_BITS;
  localparam int CNT_W = $clog2(B_MASK_WIDTH+1);
  localparam int IDX_W = (B_MASK_WIDTH > 1) ? $clog2(B_MASK_WIDTH) : 1;

  logic [MAP_W-1:0]        slot_map    [B_MASK_WIDTH];
  logic [PHYS_REG_SZ-1:0]  slot_free   [B_MASK_WIDTH];
  logic [ROB_SZ_BITS-1:0]  slot_rob    [B_MASK_WIDTH];
  logic [B_MASK_WIDTH-1:0] slot_parent [B_MASK_WIDTH];

  logic                    onehot, live_hit, res_ok, res_bad, res_correct, res_mispred;
  logic [IDX_W-1:0]        res_idx;
  logic [B_MASK_WIDTH-1:0] squash_set, clear_set, correct_clr, push_ok, push_clash;

  always_comb begin
    onehot      = (resolve_bit != '0) &&
                  ((resolve_bit & (resolve_bit - B_MASK_WIDTH'(1))) == '0);
    live_hit    = |(resolve_bit & b_mask_reg);
    res_ok      = resolve_valid & onehot & live_hit;
    res_bad     = resolve_valid & ~res_ok;
    res_correct = res_ok & ~resolve_mispred;
    res_mispred = res_ok & resolve_mispred;
    correct_clr = {B_MASK_WIDTH{res_correct}} & resolve_bit;

    res_idx = '0;
    for (int unsigned i = 0; i < B_MASK_WIDTH; i++)
      if (resolve_bit[i]) res_idx = IDX_W'(i);

    // The mispredicted branch plus every live branch that recorded it as a parent.
    squash_set = '0;
    if (res_mispred) begin
      squash_set = resolve_bit;
      for (int unsigned j = 0; j < B_MASK_WIDTH; j++)
        if (b_mask_reg[j] && slot_parent[j][res_idx]) squash_set[j] = 1'b1;
    end
    clear_set = correct_clr | squash_set;

    // A slot freed by a correct resolve this cycle may be re-pushed at the same edge.
    for (int unsigned i = 0; i < B_MASK_WIDTH; i++) begin
      push_clash[i] = push_valid[i] & ~res_mispred & b_mask_reg[i] & ~clear_set[i];
      push_ok[i]    = push_valid[i] & ~res_mispred & ~(b_mask_reg[i] & ~clear_set[i]);
    end

    bs_free_count = '0;
    for (int unsigned i = 0; i < B_MASK_WIDTH; i++)
      if (!b_mask_reg[i]) bs_free_count = bs_free_count + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < B_MASK_WIDTH; i++) begin
      if (push_ok[i]) begin
        slot_map[i]    <= push_map_table[i*MAP_W +: MAP_W];
        slot_free[i]   <= push_free_list[i*PHYS_REG_SZ +: PHYS_REG_SZ] | retire_free;
        slot_rob[i]    <= push_rob_tail[i*ROB_SZ_BITS +: ROB_SZ_BITS];
        slot_parent[i] <= push_parent_mask[i*B_MASK_WIDTH +: B_MASK_WIDTH] & ~correct_clr;
      end else begin
        if (b_mask_reg[i]) slot_free[i] <= slot_free[i] | retire_free;
        slot_parent[i] <= slot_parent[i] & ~correct_clr;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      b_mask_reg        <= '0;
      restore_valid     <= 1'b0;
      map_table_restore <= '0;
      free_list_restore <= '0;
      rob_tail_restore  <= '0;
      squash_mask       <= '0;
      resolved_mask     <= '0;
      bs_error          <= 1'b0;
    end else begin
      b_mask_reg    <= (b_mask_reg & ~clear_set) | push_ok;
      restore_valid <= res_mispred;
      squash_mask   <= squash_set;
      resolved_mask <= correct_clr;
      if (res_bad || (push_clash != '0)) bs_error <= 1'b1;
      if (res_mispred) begin
        map_table_restore <= slot_map[res_idx];
        free_list_restore <= slot_free[res_idx] | retire_free;
        rob_tail_restore  <= slot_rob[res_idx];
      end
    end
  end

endmodule

// File: tb/tb_branch_stack.sv
// Bench for branch_stack: directed scenarios plus random traffic, checked against
// a per-branch record model of live branches, checkpoints and recovery.
module tb_branch_stack;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   pv;
  logic [767:0] pmap;
  logic [255:0] pfree;
  logic [19:0]  prob;
  logic [15:0]  ppar;
  logic [63:0]  rfree;
  logic         rv;
  logic [3:0]   rbit;
  logic         rmis;

  logic [3:0]   b_mask_reg;
  logic [2:0]   bs_free_count;
  logic         restore_valid;
  logic [191:0] map_table_restore;
  logic [63:0]  free_list_restore;
  logic [4:0]   rob_tail_restore;
  logic [3:0]   squash_mask;
  logic [3:0]   resolved_mask;
  logic         bs_error;

  branch_stack #(
    .B_MASK_WIDTH(4), .ARCH_REG_SZ(32), .PHYS_REG_SZ(64), .PREG_BITS(6), .ROB_SZ_BITS(5)
  ) dut (
    .clock(clock), .reset(reset),
    .push_valid(pv), .push_map_table(pmap), .push_free_list(pfree),
    .push_rob_tail(prob), .push_parent_mask(ppar), .retire_free(rfree),
    .resolve_valid(rv), .resolve_bit(rbit), .resolve_mispred(rmis),
    .b_mask_reg(b_mask_reg), .bs_free_count(bs_free_count), .restore_valid(restore_valid),
    .map_table_restore(map_table_restore), .free_list_restore(free_list_restore),
    .rob_tail_restore(rob_tail_restore), .squash_mask(squash_mask),
    .resolved_mask(resolved_mask), .bs_error(bs_error)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int miscompares = 0;

  // Reference: one record per live branch slot
  logic [3:0]   m_live;
  logic [191:0] m_map  [4];
  logic [63:0]  m_free [4];
  logic [4:0]   m_rob  [4];
  logic [3:0]   m_par  [4];
  logic         m_err;
  logic         e_rv;
  logic [3:0]   e_sq, e_rs;
  logic [4:0]   e_rob;
  logic [63:0]  e_free;
  logic [191:0] e_map;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    pv = '0; pmap = '0; pfree = '0; prob = '0; ppar = '0;
    rfree = '0; rv = 1'b0; rbit = '0; rmis = 1'b0;
  endtask

  task automatic push(input int i, input logic [4:0] rob, input logic [3:0] par,
                      input logic [63:0] fl);
    pv[i] = 1'b1;
    prob[i*5 +: 5]    = rob;
    ppar[i*4 +: 4]    = par;
    pfree[i*64 +: 64] = fl;
    for (int w = 0; w < 6; w++) pmap[i*192 + w*32 +: 32] = $urandom;
  endtask

  task automatic resolve(input logic [3:0] b, input logic mis);
    rv = 1'b1; rbit = b; rmis = mis;
  endtask

  task automatic check_outputs();
    chk("b_mask_reg", b_mask_reg, m_live);
    chk("bs_free_count", bs_free_count, 4 - $countones(m_live));
    chk("restore_valid", restore_valid, e_rv);
    chk("squash_mask", squash_mask, e_sq);
    chk("resolved_mask", resolved_mask, e_rs);
    chk("bs_error", bs_error, m_err);
    if (e_rv) begin
      chk("rob_tail_restore", rob_tail_restore, e_rob);
      chk("free_list_restore", free_list_restore, e_free);
      chk("map_table_restore", map_table_restore, e_map);
    end
  endtask

  // Apply current inputs for one clock, advance the model, then check.
  task automatic cycle();
    int k;
    bit hit, cor, mis;
    logic [3:0] nl, sq;
    hit = rv && ($countones(rbit) == 1) && ((m_live & rbit) != 0);
    cor = hit && !rmis;
    mis = hit && rmis;
    if (rv && !hit) m_err = 1'b1;
    k = 0;
    for (int i = 0; i < 4; i++) if (rbit[i]) k = i;
    nl = m_live;
    sq = '0;
    e_rv = mis;
    e_rs = cor ? rbit : 4'b0;
    if (cor) begin
      nl[k] = 1'b0;
      for (int j = 0; j < 4; j++) m_par[j][k] = 1'b0;
    end
    if (mis) begin
      sq[k] = 1'b1;
      for (int j = 0; j < 4; j++) if (m_live[j] && m_par[j][k]) sq[j] = 1'b1;
      e_rob = m_rob[k]; e_free = m_free[k] | rfree; e_map = m_map[k];
      nl = nl & ~sq;
    end
    e_sq = sq;
    for (int j = 0; j < 4; j++) if (m_live[j]) m_free[j] = m_free[j] | rfree;
    if (!mis) begin
      for (int i = 0; i < 4; i++) begin
        if (pv[i]) begin
          if (nl[i]) m_err = 1'b1;
          else begin
            nl[i] = 1'b1;
            m_map[i]  = pmap[i*192 +: 192];
            m_free[i] = pfree[i*64 +: 64] | rfree;
            m_rob[i]  = prob[i*5 +: 5];
            m_par[i]  = ppar[i*4 +: 4] & ~e_rs;
          end
        end
      end
    end
    m_live = nl;
    @(posedge clock);
    #1;
    nvec++;
    check_outputs();
    clear_inputs();
  endtask

  // Reset is asynchronous: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_b_mask_reg", b_mask_reg, 0);
    chk("rst_restore_valid", restore_valid, 0);
    chk("rst_bs_free_count", bs_free_count, 4);
    chk("rst_squash_mask", squash_mask, 0);
    chk("rst_resolved_mask", resolved_mask, 0);
    chk("rst_bs_error", bs_error, 0);
    chk("rst_rob_tail_restore", rob_tail_restore, 0);
    chk("rst_free_list_restore", free_list_restore, 0);
    chk("rst_map_table_restore", map_table_restore, 0);
    nvec++;
    m_live = '0; m_err = 1'b0; e_rv = 1'b0; e_sq = '0; e_rs = '0;
    e_rob = '0; e_free = '0; e_map = '0;
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [3:0] r;
    int idx;
    clear_inputs();
    for (int j = 0; j < 4; j++) begin
      m_map[j] = '0; m_free[j] = '0; m_rob[j] = '0; m_par[j] = '0;
    end
    do_reset();

    // Mispredict the oldest branch squashes its child; then reset while the restore is pending.
    push(0, 5'd5, 4'b0000, 64'h0);       cycle();
    push(1, 5'd9, 4'b0001, 64'h0);       cycle();
    chk("t2_mask_0011", b_mask_reg, 4'b0011);
    resolve(4'b0001, 1'b1);              cycle();
    chk("t2_restore_valid", restore_valid, 1);
    chk("t2_rob_tail_5", rob_tail_restore, 5);
    chk("t2_squash_0011", squash_mask, 4'b0011);
    chk("t2_mask_0000", b_mask_reg, 4'b0000);
    push(0, 5'd1, 4'b0000, 64'h0);       cycle();
    push(1, 5'd2, 4'b0001, 64'h0);       cycle();
    resolve(4'b0010, 1'b1);              cycle();
    do_reset();

    // Correct resolve retires the parent; the child then squashes alone.
    push(0, 5'd3, 4'b0000, 64'h0);       cycle();
    push(1, 5'd4, 4'b0001, 64'h0);       cycle();
    resolve(4'b0001, 1'b0);              cycle();
    chk("t3_mask_0010", b_mask_reg, 4'b0010);
    chk("t3_resolved_0001", resolved_mask, 4'b0001);
    cycle();
    chk("t3_resolved_clear", resolved_mask, 4'b0000);
    resolve(4'b0010, 1'b1);              cycle();
    chk("t3_squash_0010", squash_mask, 4'b0010);

    // Registers freed by retire after the checkpoint must appear in the restore.
    do_reset();
    push(2, 5'd17, 4'b0000, 64'h0);      cycle();
    cycle();
    rfree[40] = 1'b1;                    cycle();
    resolve(4'b0100, 1'b1);              cycle();
    chk("t4_free40", free_list_restore[40], 1);

    // Full stack, push to an occupied slot, resolve of a retired bit.
    do_reset();
    push(0, 5'd10, 4'b0000, 64'h0);
    push(1, 5'd11, 4'b0001, 64'h0);
    push(2, 5'd12, 4'b0011, 64'h0);
    push(3, 5'd13, 4'b0111, 64'h0);      cycle();
    chk("t5_full_count", bs_free_count, 0);
    push(3, 5'd31, 4'b0000, 64'hffff);   cycle();
    chk("t5_clash_error", bs_error, 1);
    resolve(4'b1000, 1'b1);              cycle();
    chk("t5_entry_unchanged", rob_tail_restore, 13);
    resolve(4'b1000, 1'b0);              cycle();
    chk("t5_nonlive_mask", b_mask_reg, 4'b0111);
    chk("t5_error_sticky", bs_error, 1);
    resolve(4'b0110, 1'b0);              cycle();

    // Same-cycle interactions between resolve and push.
    do_reset();
    push(0, 5'd6, 4'b0000, 64'h0);       cycle();
    push(1, 5'd8, 4'b0001, 64'h0);       cycle();
    resolve(4'b0010, 1'b1);
    push(2, 5'd20, 4'b0011, 64'h0);      cycle();
    chk("t6_push_ignored", b_mask_reg[2], 0);
    resolve(4'b0001, 1'b0);
    push(0, 5'd7, 4'b0000, 64'h0);       cycle();
    chk("t6_repush_live", b_mask_reg[0], 1);
    chk("t6_repush_noerr", bs_error, 0);
    resolve(4'b0001, 1'b1);              cycle();
    chk("t6_repush_rob", rob_tail_restore, 7);

    // Random legal traffic, then traffic that may also violate the protocol.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < 24; w++) pmap[w*32 +: 32] = $urandom;
      for (int w = 0; w < 8; w++) pfree[w*32 +: 32] = $urandom;
      prob  = 20'($urandom);
      rfree = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (n < 250) begin
        pv = 4'($urandom) & 4'($urandom) & ~m_live;
        for (int i = 0; i < 4; i++) ppar[i*4 +: 4] = 4'($urandom) & m_live;
        if (m_live != '0 && $urandom_range(0, 2) == 0) begin
          do begin
            idx = $urandom_range(0, 3);
          end while (!m_live[idx]);
          r = '0;
          r[idx] = 1'b1;
          resolve(r, ($urandom_range(0, 3) == 0));
        end
      end else begin
        pv   = 4'($urandom) & 4'($urandom);
        ppar = 16'($urandom);
        if ($urandom_range(0, 1) == 0) resolve(4'($urandom), 1'($urandom));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end

endmodule
